// File: rtl/event_handshake_tx.sv
// Transmit side of a four-phase req/ack event handshake.
// Local event pulses are queued in a saturating counter; one req cycle per event.
module event_handshake_tx #(
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             event_in,
    input  logic             ack_in,
    input  logic             clear_overflow,
    output logic             req_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] PEND_MAX  = '1;
    localparam logic [CNT_W-1:0] PEND_ZERO = '0;
    localparam logic [CNT_W-1:0] PEND_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ_HI = 2'd1,
        ST_REQ_LO = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   req_q, req_d;
    logic [CNT_W-1:0]       pending_q, pending_d;
    logic                   overflow_q, overflow_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                   ack_sync;
    logic                   dequeue;
    logic                   ovf_set;

    assign ack_sync = ack_sync_q[SYNC_STAGES-1];

    // Shift ack_in through the synchronizer chain
    always_comb begin
        ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ack_in};
    end

    // Handshake FSM: launch on pending, wait ack high, then wait ack low
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        dequeue = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pending_q != PEND_ZERO) begin
                    state_d = ST_REQ_HI;
                    req_d   = 1'b1;
                    dequeue = 1'b1;
                end
            end
            ST_REQ_HI: begin
                if (ack_sync) begin
                    state_d = ST_REQ_LO;
                    req_d   = 1'b0;
                end
            end
            ST_REQ_LO: begin
                if (!ack_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Pending counter: simultaneous inc/dec cancels; inc at max drops the event
    always_comb begin
        pending_d = pending_q;
        ovf_set   = 1'b0;
        if (event_in && !dequeue) begin
            if (pending_q == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pending_d = pending_q + PEND_ONE;
            end
        end else if (dequeue && !event_in) begin
            pending_d = pending_q - PEND_ONE;
        end
    end

    // Sticky overflow; a new drop wins over a same-cycle clear
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            ack_sync_q <= ack_sync_d;
        end
    end

    assign req_out  = req_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;
    // Busy reflects current state directly, no extra register stage
    assign busy     = (state_q != ST_IDLE) || (pending_q != PEND_ZERO);

endmodule

// File: tb/tb_event_handshake_tx.sv
// Bench for event_handshake_tx: directed stimulus, req pulses checked via scoreboard.
module tb_event_handshake_tx;

    localparam int unsigned CNT_W = 2;
    localparam int unsigned SYNC  = 2;

    logic             clk;
    logic             reset;
    logic             event_in;
    logic             ack_in;
    logic             clear_overflow;
    logic             req_out;
    logic             busy;
    logic [CNT_W-1:0] pending;
    logic             overflow;

    int checks;
    int errors;
    int exp_q[$];
    int next_id;
    int pulse_cnt;
    bit ack_en;

    event_handshake_tx #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
        .clk            (clk),
        .reset          (reset),
        .event_in       (event_in),
        .ack_in         (ack_in),
        .clear_overflow (clear_overflow),
        .req_out        (req_out),
        .busy           (busy),
        .pending        (pending),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(next_id);
            next_id++;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((busy || req_out || ack_in) && n < budget) begin
            tick();
            n++;
        end
        chk(name, int'(busy || req_out || ack_in), 0);
    endtask

    // Far-side model: ack rises on the 3rd negedge seeing req high, drops once req is low
    initial begin
        int cnt;
        cnt    = 0;
        ack_in = 1'b0;
        forever begin
            @(negedge clk);
            if (!ack_en) begin
                ack_in = 1'b0;
                cnt    = 0;
            end else if (req_out && !ack_in) begin
                cnt++;
                if (cnt == 3) begin
                    ack_in = 1'b1;
                    cnt    = 0;
                end
            end else if (!req_out && ack_in) begin
                ack_in = 1'b0;
            end
        end
    end

    // Monitor: each req rising edge must match the next scoreboard entry
    initial begin
        logic prev;
        int   id;
        prev      = 1'b0;
        pulse_cnt = 0;
        forever begin
            @(negedge clk);
            if (req_out && !prev) begin
                if (exp_q.size() == 0) begin
                    chk("req_unexpected", 1, 0);
                end else begin
                    id = exp_q.pop_front();
                    chk("req_pulse_id", pulse_cnt, id);
                end
                pulse_cnt++;
            end
            prev = req_out;
        end
    end

    initial begin
        checks         = 0;
        errors         = 0;
        next_id        = 0;
        ack_en         = 1'b1;
        reset          = 1'b0;
        event_in       = 1'b0;
        clear_overflow = 1'b0;
        repeat (3) tick();
        chk("rst_req", int'(req_out), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b1;
        tick();

        // Single event with exact latency through the full handshake
        event_in = 1'b1;
        expect_pulses(1);
        tick();
        event_in = 1'b0;
        chk("single_pend_k", int'(pending), 1);
        chk("single_req_k", int'(req_out), 0);
        tick();
        chk("single_req_k1", int'(req_out), 1);
        chk("single_pend_k1", int'(pending), 0);
        for (int i = 2; i <= 9; i++) begin
            tick();
            chk($sformatf("single_req_k%0d", i), int'(req_out), (i <= 5) ? 1 : 0);
            chk($sformatf("single_busy_k%0d", i), int'(busy), (i <= 8) ? 1 : 0);
        end

        // Burst of three events
        expect_pulses(3);
        event_in = 1'b1;
        tick();
        chk("burst_pend0", int'(pending), 1);
        tick();
        chk("burst_pend1", int'(pending), 1);
        tick();
        chk("burst_pend2", int'(pending), 2);
        event_in = 1'b0;
        wait_idle("burst_idle", 300);
        chk("burst_pend_end", int'(pending), 0);
        chk("burst_ovf", int'(overflow), 0);

        // Overflow with ack held low: 5 events, one in flight, three queued, one lost
        ack_en = 1'b0;
        tick();
        expect_pulses(4);
        event_in = 1'b1;
        repeat (5) tick();
        event_in = 1'b0;
        chk("ovf_pend", int'(pending), 3);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_req", int'(req_out), 1);
        chk("ovf_busy", int'(busy), 1);

        // Saturating event and clear together: set wins
        event_in       = 1'b1;
        clear_overflow = 1'b1;
        tick();
        event_in = 1'b0;
        chk("clr_vs_set_ovf", int'(overflow), 1);
        chk("clr_vs_set_pend", int'(pending), 3);
        tick();
        clear_overflow = 1'b0;
        chk("clr_ovf", int'(overflow), 0);

        ack_en = 1'b1;
        wait_idle("ovf_drain_idle", 500);
        chk("ovf_drain_pend", int'(pending), 0);

        // Event arriving on the dequeue cycle keeps pending at one
        expect_pulses(2);
        event_in = 1'b1;
        tick();
        chk("incdec_pend_k", int'(pending), 1);
        tick();
        event_in = 1'b0;
        chk("incdec_pend", int'(pending), 1);
        chk("incdec_req", int'(req_out), 1);
        wait_idle("incdec_idle", 300);

        // Reset during REQ_HI with two events queued
        ack_en = 1'b0;
        tick();
        expect_pulses(1);
        event_in = 1'b1;
        repeat (3) tick();
        event_in = 1'b0;
        chk("midrst_pre_req", int'(req_out), 1);
        chk("midrst_pre_pend", int'(pending), 2);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_req", int'(req_out), 0);
        chk("midrst_pend", int'(pending), 0);
        chk("midrst_busy", int'(busy), 0);
        tick();
        reset  = 1'b1;
        ack_en = 1'b1;
        repeat (20) tick();
        chk("postrst_req", int'(req_out), 0);
        chk("postrst_busy", int'(busy), 0);

        chk("sb_empty", exp_q.size(), 0);
        chk("pulse_total", pulse_cnt, next_id);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
